// File: rtl/sctag_snpq_buf_pkg.sv
// Shared definitions for the snoop request queue: beat-0 field positions,
// fill FSM encoding and the packing order of the head inst bus.
package sctag_snpq_buf_pkg;

    localparam int BEAT_W       = 32;
    localparam int ADDR_W       = 40;

    // Beat-0 (header beat) field positions
    localparam int HAS_DATA_BIT = 31;
    localparam int POISON_BIT   = 30;
    localparam int HDR_LSB      = 8;
    localparam int ADDR_HI_MSB  = 7;
    localparam int ADDR_HI_LSB  = 0;

    // The rdma tag write only needs the 64-byte line address
    localparam int WR_ADDR_LSB  = 6;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_ADDR = 2'd1,
        FILL_DATA = 2'd2
    } fill_state_e;

    // Inst bus is packed {poison, rent, hdr} with hdr in the LSBs
    function automatic int instRentLsb(input int hdr_w);
        return hdr_w;
    endfunction

    function automatic int instPoisonBit(input int hdr_w, input int rent_w);
        return hdr_w + rent_w;
    endfunction

endpackage

// File: rtl/sctag_snpq_entry.sv
// One snoop queue entry: payload registers with per-field write enables
// plus the valid and has-data control bits.
module sctag_snpq_entry
    import sctag_snpq_buf_pkg::*;
#(
    parameter int HDR_W      = 19,
    parameter int DATA_BEATS = 2,
    parameter int RENT_W     = 2,
    parameter int BC_W       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [BEAT_W-1:0]          beat_i,
    input  logic                       hdr_we_i,
    input  logic                       addr_we_i,
    input  logic                       data_we_i,
    input  logic [BC_W-1:0]            data_idx_i,
    input  logic                       rent_we_i,
    input  logic [RENT_W-1:0]          rent_i,
    input  logic                       set_vld_i,
    input  logic                       clr_vld_i,
    output logic                       vld_o,
    output logic                       has_data_o,
    output logic                       poison_o,
    output logic [HDR_W-1:0]           hdr_o,
    output logic [RENT_W-1:0]          rent_o,
    output logic [ADDR_W-1:0]          addr_o,
    output logic [BEAT_W*DATA_BEATS-1:0] data_o
);

    logic                vld_q;
    logic                has_data_q;
    logic                poison_q;
    logic [HDR_W-1:0]    hdr_q;
    logic [RENT_W-1:0]   rent_q;
    logic [7:0]          addr_hi_q;
    logic [BEAT_W-1:0]   addr_lo_q;
    logic [BEAT_W-1:0]   data_q [DATA_BEATS];

    // Control bits are reset so winv and vld read 0 out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= 1'b0;
            has_data_q <= 1'b0;
        end else begin
            if (hdr_we_i) begin
                has_data_q <= beat_i[HAS_DATA_BIT];
            end
            if (set_vld_i) begin
                vld_q <= 1'b1;
            end else if (clr_vld_i) begin
                vld_q <= 1'b0;
            end
        end
    end

    // Payload registers carry no reset; they are qualified by vld_q
    always_ff @(posedge clk) begin
        if (hdr_we_i) begin
            poison_q  <= beat_i[POISON_BIT];
            hdr_q     <= beat_i[HDR_LSB +: HDR_W];
            addr_hi_q <= beat_i[ADDR_HI_MSB:ADDR_HI_LSB];
        end
        if (addr_we_i) begin
            addr_lo_q <= beat_i;
        end
        if (data_we_i) begin
            data_q[data_idx_i] <= beat_i;
        end
        if (rent_we_i) begin
            rent_q <= rent_i;
        end
    end

    assign vld_o      = vld_q;
    assign has_data_o = has_data_q;
    assign poison_o   = poison_q;
    assign hdr_o      = hdr_q;
    assign rent_o     = rent_q;
    assign addr_o     = {addr_hi_q, addr_lo_q};

    // Data beat 0 lands in the most significant word
    for (genvar i = 0; i < DATA_BEATS; i++) begin : g_data
        assign data_o[BEAT_W*(DATA_BEATS-1-i) +: BEAT_W] = data_q[i];
    end

endmodule

// File: rtl/sctag_snpq_buf.sv
// Snoop request queue: assembles JBI beats into DEPTH entries and presents
// the oldest complete request to the arbiter datapath.
module sctag_snpq_buf
    import sctag_snpq_buf_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int HDR_W      = 19,
    parameter int DATA_BEATS = 2,
    parameter int RENT_W     = 2
) (
    input  logic                         rclk,
    input  logic                         arst_l,
    input  logic                         jbi_req_vld,
    input  logic [31:0]                  jbi_req_buf,
    input  logic [RENT_W-1:0]            rdmad_wr_entry,
    input  logic                         arb_snpq_pop,
    output logic                         snpq_arbdp_vld,
    output logic [HDR_W+RENT_W:0]        snpq_arbdp_inst,
    output logic [39:0]                  snpq_arbdp_addr,
    output logic [32*DATA_BEATS-1:0]     snpq_arbdp_data,
    output logic [33:0]                  snpq_wr_addr,
    output logic                         snpq_winv,
    output logic                         snpq_full,
    output logic                         snpq_ovfl_err
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BC_W   = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
    localparam int DATA_W = 32 * DATA_BEATS;

    fill_state_e       state_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [BC_W-1:0]   beat_cnt_q;
    logic              ovfl_q;

    logic [DEPTH-1:0]  ent_vld;
    logic [DEPTH-1:0]  ent_has_data;
    logic [DEPTH-1:0]  ent_poison;
    logic [HDR_W-1:0]  ent_hdr  [DEPTH];
    logic [RENT_W-1:0] ent_rent [DEPTH];
    logic [39:0]       ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DATA_W > 0 ? DEPTH : 1];

    logic full;
    logic hdr_acc;
    logic addr_acc;
    logic data_acc;
    logic last_data;
    logic commit;
    logic pop;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign hdr_acc   = (state_q == FILL_IDLE) && jbi_req_vld && !full;
    assign addr_acc  = (state_q == FILL_ADDR) && jbi_req_vld;
    assign data_acc  = (state_q == FILL_DATA) && jbi_req_vld;
    assign last_data = (beat_cnt_q == BC_W'(DATA_BEATS - 1));
    assign commit    = (addr_acc && !ent_has_data[wr_ptr_q]) || (data_acc && last_data);
    assign pop       = arb_snpq_pop && ent_vld[rd_ptr_q];

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic sel_wr;
        logic sel_rd;
        assign sel_wr = (wr_ptr_q == PTR_W'(g));
        assign sel_rd = (rd_ptr_q == PTR_W'(g));

        sctag_snpq_entry #(
            .HDR_W      (HDR_W),
            .DATA_BEATS (DATA_BEATS),
            .RENT_W     (RENT_W),
            .BC_W       (BC_W)
        ) u_entry (
            .clk        (rclk),
            .rst_n      (arst_l),
            .beat_i     (jbi_req_buf),
            .hdr_we_i   (hdr_acc && sel_wr),
            .addr_we_i  (addr_acc && sel_wr),
            .data_we_i  (data_acc && sel_wr),
            .data_idx_i (beat_cnt_q),
            .rent_we_i  (data_acc && sel_wr && (beat_cnt_q == '0)),
            .rent_i     (rdmad_wr_entry),
            .set_vld_i  (commit && sel_wr),
            .clr_vld_i  (pop && sel_rd),
            .vld_o      (ent_vld[g]),
            .has_data_o (ent_has_data[g]),
            .poison_o   (ent_poison[g]),
            .hdr_o      (ent_hdr[g]),
            .rent_o     (ent_rent[g]),
            .addr_o     (ent_addr[g]),
            .data_o     (ent_data[g])
        );
    end

    // Fill FSM: walks header, address and data beats; drops headers while full
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q    <= FILL_IDLE;
            beat_cnt_q <= '0;
            ovfl_q     <= 1'b0;
        end else if (jbi_req_vld) begin
            case (state_q)
                FILL_IDLE: begin
                    if (full) begin
                        ovfl_q <= 1'b1;
                    end else begin
                        state_q <= FILL_ADDR;
                    end
                end
                FILL_ADDR: begin
                    beat_cnt_q <= '0;
                    state_q    <= ent_has_data[wr_ptr_q] ? FILL_DATA : FILL_IDLE;
                end
                FILL_DATA: begin
                    if (last_data) begin
                        beat_cnt_q <= '0;
                        state_q    <= FILL_IDLE;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + BC_W'(1);
                    end
                end
                default: state_q <= FILL_IDLE;
            endcase
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (commit) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({commit, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign snpq_arbdp_vld  = ent_vld[rd_ptr_q];
    assign snpq_arbdp_addr = ent_addr[rd_ptr_q];
    assign snpq_arbdp_data = ent_data[rd_ptr_q];
    assign snpq_arbdp_inst[HDR_W-1:0] = ent_hdr[rd_ptr_q];
    assign snpq_arbdp_inst[instRentLsb(HDR_W) +: RENT_W] = ent_rent[rd_ptr_q];
    assign snpq_arbdp_inst[instPoisonBit(HDR_W, RENT_W)] = ent_poison[rd_ptr_q];
    assign snpq_wr_addr    = ent_addr[wr_ptr_q][39:WR_ADDR_LSB];
    assign snpq_winv       = ent_has_data[wr_ptr_q];
    assign snpq_full       = full;
    assign snpq_ovfl_err   = ovfl_q;

endmodule
